// File: rtl/microcode_sequencer.sv
// microcode_sequencer: drives the microcode EPROM, latches each 64-bit word into
// the microinstruction register and sequences the micro-PC (next, jump,
// conditional jump, call/return stack, opcode dispatch, halt).
//
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous active-high reset
//   _rom_cs        EPROM chip select, active low
//   _rom_oe        EPROM output enable, active low
//   rom_addr       EPROM address (ADDR_BITS)
//   rom_data       EPROM data (WIDTH)
//   cond           datapath condition flags (8)
//   dispatch_addr  entry point from the opcode decoder (ADDR_BITS)
//   stall          downstream not ready; holds the current microinstruction
//   step           single-step request (only with UCODE_SINGLESTEP_EN)
//   uinst          latched microinstruction (WIDTH)
//   uinst_valid    uinst is valid for the datapath this cycle
//   halted         sequencer has stopped
//   stack_err      sticky return-stack overflow/underflow flag
//
// Optional feature macro: UCODE_SINGLESTEP_EN adds the step port and a
// STEPWAIT state between microinstructions.
module microcode_sequencer #(
    parameter int WIDTH       = 64,
    parameter int ADDR_BITS   = 9,
    parameter int STACK_DEPTH = 4,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 _rom_cs,
    output logic                 _rom_oe,
    output logic [ADDR_BITS-1:0] rom_addr,
    input  logic [WIDTH-1:0]     rom_data,
    input  logic [7:0]           cond,
    input  logic [ADDR_BITS-1:0] dispatch_addr,
    input  logic                 stall,
`ifdef UCODE_SINGLESTEP_EN
    input  logic                 step,
`endif
    output logic [WIDTH-1:0]     uinst,
    output logic                 uinst_valid,
    output logic                 halted,
    output logic                 stack_err
);
    // sp counts occupied entries, so it needs to represent STACK_DEPTH itself
    localparam int SPW = $clog2(STACK_DEPTH + 1);
    localparam int CW  = 4;

    localparam logic [2:0] OP_JUMP     = 3'd1;
    localparam logic [2:0] OP_CJUMP    = 3'd2;
    localparam logic [2:0] OP_CALL     = 3'd3;
    localparam logic [2:0] OP_RET      = 3'd4;
    localparam logic [2:0] OP_DISPATCH = 3'd5;
    localparam logic [2:0] OP_HALT     = 3'd6;

    typedef enum logic [2:0] {
        S_RESET,
        S_FETCH,
        S_ISSUE,
        S_HALTED
`ifdef UCODE_SINGLESTEP_EN
        , S_STEPWAIT
`endif
    } state_t;

    state_t               state;
    logic [ADDR_BITS-1:0] upc;
    logic [SPW-1:0]       sp;
    logic [CW-1:0]        count;
    // sized to the full sp range so sp indexes it without truncation
    logic [ADDR_BITS-1:0] stack [2**SPW];

    logic [2:0]           op;
    logic [ADDR_BITS-1:0] target;
    logic [ADDR_BITS-1:0] upc_inc;
    logic [ADDR_BITS-1:0] next_upc;
    logic [SPW-1:0]       sp_dec;
    logic                 taken;
    logic                 push_ok;
    logic                 pop_ok;

    always_comb begin
        op       = uinst[2:0];
        target   = uinst[7 +: ADDR_BITS];
        upc_inc  = upc + 1'b1;
        taken    = cond[uinst[5:3]] ^ uinst[6];
        push_ok  = sp != SPW'(STACK_DEPTH);
        pop_ok   = sp != '0;
        sp_dec   = sp - 1'b1;
        next_upc = op == OP_JUMP     ? target :
                   op == OP_CJUMP    ? (taken ? target : upc_inc) :
                   op == OP_CALL     ? target :
                   op == OP_RET      ? (pop_ok ? stack[sp_dec] : '0) :
                   op == OP_DISPATCH ? dispatch_addr :
                   op == OP_HALT     ? upc : upc_inc;
    end

`ifdef UCODE_SINGLESTEP_EN
    logic step_q;
    logic step_rise;

    always_ff @(posedge clk) begin
        if (reset) begin
            step_q    <= 1'b0;
            step_rise <= 1'b0;
        end else begin
            step_q    <= step;
            step_rise <= step & ~step_q;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_RESET;
            upc         <= '0;
            sp          <= '0;
            count       <= '0;
            rom_addr    <= '0;
            _rom_cs     <= 1'b1;
            _rom_oe     <= 1'b1;
            uinst       <= '0;
            uinst_valid <= 1'b0;
            halted      <= 1'b0;
            stack_err   <= 1'b0;
        end else begin
            case (state)
                S_RESET: begin
                    state    <= S_FETCH;
                    count    <= '0;
                    rom_addr <= upc;
                    _rom_cs  <= 1'b0;
                    _rom_oe  <= 1'b0;
                end
                S_FETCH: begin
                    count <= count + 1'b1;
                    // the ROM drives 0 while disabled, so data is only taken here
                    if (count == CW'(WAIT_CYCLES - 1)) begin
                        uinst       <= rom_data;
                        uinst_valid <= 1'b1;
                        _rom_cs     <= 1'b1;
                        _rom_oe     <= 1'b1;
                        state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!stall) begin
                        uinst_valid <= 1'b0;
                        count       <= '0;
                        upc         <= next_upc;
                        if (op == OP_CALL) begin
                            if (push_ok) begin
                                stack[sp] <= upc_inc;
                                sp        <= sp + 1'b1;
                            end else begin
                                stack_err <= 1'b1;
                            end
                        end
                        if (op == OP_RET) begin
                            if (pop_ok) sp <= sp_dec;
                            else stack_err <= 1'b1;
                        end
                        if (op == OP_HALT) begin
                            state  <= S_HALTED;
                            halted <= 1'b1;
                        end else begin
`ifdef UCODE_SINGLESTEP_EN
                            state <= S_STEPWAIT;
`else
                            state    <= S_FETCH;
                            rom_addr <= next_upc;
                            _rom_cs  <= 1'b0;
                            _rom_oe  <= 1'b0;
`endif
                        end
                    end
                end
`ifdef UCODE_SINGLESTEP_EN
                S_STEPWAIT: begin
                    if (step_rise) begin
                        state    <= S_FETCH;
                        rom_addr <= upc;
                        _rom_cs  <= 1'b0;
                        _rom_oe  <= 1'b0;
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_microcode_sequencer.sv
// tb_microcode_sequencer: randomized self-checking bench with an EPROM model and
// an address-level reference model of micro-PC sequencing.
module tb_microcode_sequencer;
    localparam logic [2:0] NEXT = 3'd0, JUMP = 3'd1, CJUMP = 3'd2, CALL = 3'd3;
    localparam logic [2:0] RET = 3'd4, DISP = 3'd5, HALT = 3'd6;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        _rom_cs, _rom_oe;
    logic [8:0]  rom_addr;
    logic [63:0] rom_data;
    logic [7:0]  cond = '0;
    logic [8:0]  dispatch_addr = '0;
    logic        stall = 1'b0;
    logic [63:0] uinst;
    logic        uinst_valid, halted, stack_err;
    logic [63:0] rom [512];
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    assign rom_data = (!_rom_cs && !_rom_oe) ? rom[rom_addr] : '0;

`ifdef UCODE_SINGLESTEP_EN
    logic step, step_man = 1'b0, step_tgl = 1'b0, step_auto = 1'b1;
    always @(negedge clk) step_tgl <= ~step_tgl;
    assign step = step_auto ? step_tgl : step_man;
`endif

    microcode_sequencer dut (
        .clk(clk), .reset(reset), ._rom_cs(_rom_cs), ._rom_oe(_rom_oe),
        .rom_addr(rom_addr), .rom_data(rom_data), .cond(cond),
        .dispatch_addr(dispatch_addr), .stall(stall),
`ifdef UCODE_SINGLESTEP_EN
        .step(step),
`endif
        .uinst(uinst), .uinst_valid(uinst_valid), .halted(halted), .stack_err(stack_err)
    );

    function automatic logic [63:0] w(input logic [2:0] op, input logic [2:0] sel,
                                      input logic inv, input logic [8:0] tgt);
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        r[15:0] = {tgt, inv, sel, op};
        return r;
    endfunction

    task automatic clear_rom();
        for (int a = 0; a < 512; a++) rom[a] = w(NEXT, 3'd0, 1'b0, 9'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        stall = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Waits for the next fetch, records its address, then waits for the issue.
    task automatic fetch_issue(output logic [8:0] a, output logic [63:0] d, output bit ok);
        int n = 0;
        while (_rom_cs !== 1'b0 && n < 60) begin @(negedge clk); n++; end
        a = rom_addr;
        while (uinst_valid !== 1'b1 && n < 60) begin @(negedge clk); n++; end
        d = uinst;
        ok = n < 60;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({rom_addr, _rom_cs, _rom_oe, uinst_valid, halted, stack_err} !== {9'd0, 5'b11000} || uinst !== '0) begin
            failures++;
            $display("FAIL reset: addr=%h cs=%b oe=%b uinst=%h v=%b h=%b e=%b", rom_addr, _rom_cs, _rom_oe, uinst, uinst_valid, halted, stack_err);
        end
    endtask

    task automatic test_first_fetch();
        int n = 0;
        clear_rom();
        do_reset();
        @(negedge clk);
        checks++;
        if ({_rom_cs, _rom_oe, rom_addr, uinst_valid} !== {2'b00, 9'd0, 1'b0}) begin
            failures++;
            $display("FAIL first_edge1: cs=%b oe=%b addr=%h v=%b want 0 0 000 0", _rom_cs, _rom_oe, rom_addr, uinst_valid);
        end
        @(negedge clk);
        checks++;
        if ({_rom_cs, _rom_oe, uinst_valid} !== 3'b000) begin
            failures++;
            $display("FAIL first_edge2: cs=%b oe=%b v=%b want 0 0 0", _rom_cs, _rom_oe, uinst_valid);
        end
        @(negedge clk);
        checks++;
        if ({_rom_cs, _rom_oe, uinst_valid} !== 3'b111 || uinst !== rom[0]) begin
            failures++;
            $display("FAIL first_edge3: cs=%b oe=%b v=%b uinst=%h want 1 1 1 %h", _rom_cs, _rom_oe, uinst_valid, uinst, rom[0]);
        end
        while (_rom_cs !== 1'b0 && n < 60) begin @(negedge clk); n++; end
        checks++;
        if (_rom_cs !== 1'b0 || rom_addr !== 9'd1) begin
            failures++;
            $display("FAIL first_next: cs=%b addr=%h want 0 001", _rom_cs, rom_addr);
        end
    endtask

    task automatic test_cjump();
        logic [8:0] a, e;
        logic [63:0] d;
        bit ok;
        for (int c = 0; c < 3; c++) begin
            clear_rom();
            rom[5] = w(CJUMP, 3'd2, c == 2, 9'h40);
            cond = c == 1 ? 8'h00 : 8'h04;
            do_reset();
            for (int i = 0; i < 7; i++) begin
                e = i < 6 ? 9'(i) : (c == 0 ? 9'h40 : 9'd6);
                fetch_issue(a, d, ok);
                checks++;
                if (!ok || a !== e || d !== rom[e]) begin
                    failures++;
                    $display("FAIL cjump case%0d step%0d: addr=%h word=%h want %h %h", c, i, a, d, e, rom[e]);
                end
            end
        end
        cond = '0;
    endtask

    task automatic test_stack();
        logic [8:0] seq [11] = '{9'h0, 9'h10, 9'h20, 9'h30, 9'h40, 9'h50, 9'h31, 9'h21, 9'h11, 9'h01, 9'h0};
        logic [8:0] a;
        logic [63:0] d;
        bit ok;
        clear_rom();
        for (int i = 0; i < 5; i++) rom[seq[i]] = w(CALL, 3'd0, 1'b0, seq[i+1]);
        for (int i = 5; i < 10; i++) rom[seq[i]] = w(RET, 3'd0, 1'b0, 9'h1AB);
        do_reset();
        for (int i = 0; i < 11; i++) begin
            fetch_issue(a, d, ok);
            checks++;
            if (!ok || a !== seq[i] || d !== rom[seq[i]] || stack_err !== (i >= 5)) begin
                failures++;
                $display("FAIL stack step%0d: addr=%h err=%b want %h %b", i, a, stack_err, seq[i], i >= 5);
            end
        end
    endtask

    task automatic test_wrap_dispatch();
        logic [8:0] seq [3] = '{9'h0, 9'h1FF, 9'h0};
        logic [8:0] dseq [3] = '{9'h0, 9'h123, 9'h124};
        logic [8:0] a;
        logic [63:0] d;
        bit ok;
        clear_rom();
        rom[0] = w(JUMP, 3'd0, 1'b0, 9'h1FF);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            fetch_issue(a, d, ok);
            checks++;
            if (!ok || a !== seq[i] || d !== rom[seq[i]]) begin
                failures++;
                $display("FAIL wrap step%0d: addr=%h want %h", i, a, seq[i]);
            end
        end
        clear_rom();
        rom[0] = w(DISP, 3'd0, 1'b0, 9'h077);
        dispatch_addr = 9'h123;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            fetch_issue(a, d, ok);
            checks++;
            if (!ok || a !== dseq[i] || d !== rom[dseq[i]]) begin
                failures++;
                $display("FAIL dispatch step%0d: addr=%h want %h", i, a, dseq[i]);
            end
        end
        dispatch_addr = '0;
    endtask

    task automatic test_stall_reset();
        logic [8:0] a;
        logic [63:0] d;
        bit ok;
        int n = 0;
        clear_rom();
        do_reset();
        fetch_issue(a, d, ok);
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({uinst_valid, _rom_cs, _rom_oe} !== 3'b111 || uinst !== d) begin
                failures++;
                $display("FAIL stall cyc%0d: v=%b cs=%b oe=%b uinst=%h want 1 1 1 %h", i, uinst_valid, _rom_cs, _rom_oe, uinst, d);
            end
        end
        stall = 1'b0;
        fetch_issue(a, d, ok);
        checks++;
        if (!ok || a !== 9'd1 || d !== rom[1]) begin
            failures++;
            $display("FAIL stall_release: addr=%h want 001", a);
        end
        while (_rom_cs !== 1'b0 && n < 60) begin @(negedge clk); n++; end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({rom_addr, _rom_cs, _rom_oe, uinst_valid, halted, stack_err} !== {9'd0, 5'b11000} || uinst !== '0) begin
            failures++;
            $display("FAIL reset_in_fetch: addr=%h cs=%b oe=%b v=%b uinst=%h", rom_addr, _rom_cs, _rom_oe, uinst_valid, uinst);
        end
        reset = 1'b0;
    endtask

    task automatic test_halt();
        logic [8:0] a;
        logic [63:0] d;
        bit ok;
        clear_rom();
        rom[2] = w(HALT, 3'd0, 1'b0, 9'h10);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            fetch_issue(a, d, ok);
            checks++;
            if (!ok || a !== 9'(i) || d !== rom[i]) begin
                failures++;
                $display("FAIL halt_seq step%0d: addr=%h want %h", i, a, i);
            end
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({halted, uinst_valid, _rom_cs, _rom_oe} !== 4'b1011) begin
                failures++;
                $display("FAIL halted cyc%0d: h=%b v=%b cs=%b oe=%b want 1 0 1 1", i, halted, uinst_valid, _rom_cs, _rom_oe);
            end
        end
    endtask

    task automatic test_random();
        logic [8:0] a, pc, tgt;
        logic [63:0] d;
        logic [2:0] op, sel;
        logic inv, err;
        bit ok;
        int stk [$];
        for (int i = 0; i < 512; i++) begin
            op = 3'($urandom_range(0, 6));
            if (op == HALT) op = 3'd7;
            rom[i] = w(op, 3'($urandom), 1'($urandom), 9'($urandom));
        end
        do_reset();
        pc = '0;
        err = 1'b0;
        stk.delete();
        for (int k = 0; k < 80; k++) begin
            fetch_issue(a, d, ok);
            checks++;
            if (!ok || a !== pc || d !== rom[pc] || stack_err !== err) begin
                failures++;
                $display("FAIL random k%0d: addr=%h err=%b want %h %b", k, a, stack_err, pc, err);
            end
            cond = 8'($urandom);
            dispatch_addr = 9'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                stall = 1'b1;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                stall = 1'b0;
            end
            {tgt, inv, sel, op} = rom[pc][15:0];
            case (op)
                JUMP:  pc = tgt;
                CJUMP: pc = (cond[sel] ^ inv) ? tgt : pc + 9'd1;
                CALL: begin
                    if (stk.size() < 4) stk.push_back(int'(pc) + 1);
                    else err = 1'b1;
                    pc = tgt;
                end
                RET: begin
                    if (stk.size() > 0) pc = 9'(stk.pop_back());
                    else begin pc = '0; err = 1'b1; end
                end
                DISP:  pc = dispatch_addr;
                default: pc = pc + 9'd1;
            endcase
        end
    endtask

`ifdef UCODE_SINGLESTEP_EN
    task automatic test_step();
        int issued = 0;
        clear_rom();
        step_auto = 1'b0;
        step_man = 1'b0;
        do_reset();
        repeat (15) begin @(negedge clk); issued += int'(uinst_valid); end
        checks++;
        if (issued != 1) begin
            failures++;
            $display("FAIL step_initial: issued=%0d want 1", issued);
        end
        issued = 0;
        step_man = 1'b1;
        @(negedge clk);
        step_man = 1'b0;
        repeat (15) begin @(negedge clk); issued += int'(uinst_valid); end
        checks++;
        if (issued != 1) begin
            failures++;
            $display("FAIL step_pulse: issued=%0d want 1", issued);
        end
        step_auto = 1'b1;
    endtask
`endif

    initial begin
        clear_rom();
        test_reset();
        test_first_fetch();
        test_cjump();
        test_stack();
        test_wrap_dispatch();
        test_stall_reset();
        test_halt();
        test_random();
`ifdef UCODE_SINGLESTEP_EN
        test_step();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
